// File: rtl/aes_prng_reseed_sched.sv
// aes_prng_reseed_sched: schedules masking-PRNG reseeds from block count, software and key-touch triggers.
module aes_prng_reseed_sched #(
  parameter bit SecMasking = 1'b0,
  parameter int CntWidth   = 14
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          prng_reseed_rate_i,
  input  logic                key_touch_forces_reseed_i,
  input  logic                block_done_i,
  input  logic                key_touch_i,
  input  logic                sw_reseed_i,
  output logic                reseed_req_o,
  input  logic                reseed_ack_i,
  output logic                block_stall_o,
  output logic                reseed_done_o,
  output logic                rate_err_o,
  output logic [CntWidth-1:0] blk_cnt_o
);
  typedef enum logic {IDLE, REQ} state_e;
  state_e state_q, state_d;
  logic pend_auto, pend_sw, pend_key, rate_bad, key_hit, auto_hit, go, ack_hit;
  logic [CntWidth-1:0] cnt, cnt_inc, cnt_nxt, thr;
  always_comb begin
    rate_bad = !(prng_reseed_rate_i inside {3'b001, 3'b010, 3'b100});
    thr      = prng_reseed_rate_i == 3'b010 ? CntWidth'(64) :
               prng_reseed_rate_i == 3'b100 ? CntWidth'(8192) : CntWidth'(1);
    cnt_inc  = cnt < thr ? cnt + 1'b1 : cnt;
    cnt_nxt  = block_done_i ? cnt_inc : cnt;
    key_hit  = key_touch_i & key_touch_forces_reseed_i;
    // auto trigger is held off while a reseed is in flight; the ack clears the count
    auto_hit = SecMasking && state_q == IDLE && cnt_nxt >= thr;
    ack_hit  = state_q == REQ && reseed_ack_i;
    go       = state_q == IDLE && (pend_auto | pend_sw | pend_key | sw_reseed_i | key_hit | auto_hit);
    state_d  = go ? REQ : ack_hit ? IDLE : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pend_auto     <= 1'b0;
      pend_sw       <= 1'b0;
      pend_key      <= 1'b0;
      cnt           <= '0;
      rate_err_o    <= 1'b0;
      reseed_done_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_auto     <= !go && (pend_auto | auto_hit);
      pend_sw       <= !go && (pend_sw | sw_reseed_i);
      pend_key      <= !go && (pend_key | key_hit);
      cnt           <= ack_hit ? '0 : cnt_nxt;
      rate_err_o    <= rate_err_o | rate_bad;
      reseed_done_o <= ack_hit;
    end
  end
  assign reseed_req_o  = state_q == REQ;
  assign block_stall_o = reseed_req_o | pend_auto | pend_sw | pend_key;
  assign blk_cnt_o     = cnt;
endmodule

// File: tb/tb_aes_prng_reseed_sched.sv
// tb_aes_prng_reseed_sched: directed checks of the reseed scheduler, masked and unmasked builds.
module tb_aes_prng_reseed_sched;
  logic clk = 0, rst = 1;
  logic [2:0] rate = 3'b010;
  logic force_key = 0, blk = 0, key = 0, sw = 0, ack = 0;
  logic req, stall, done, err, nm_req, nm_stall, nm_done, nm_err;
  logic [13:0] cnt, nm_cnt;
  int n_tests = 0, n_fail = 0, n_done = 0, d0;
  logic seen;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;

  aes_prng_reseed_sched #(.SecMasking(1'b1), .CntWidth(14)) u_dut (
    .clk_i(clk), .rst_i(rst), .prng_reseed_rate_i(rate), .key_touch_forces_reseed_i(force_key),
    .block_done_i(blk), .key_touch_i(key), .sw_reseed_i(sw), .reseed_req_o(req),
    .reseed_ack_i(ack), .block_stall_o(stall), .reseed_done_o(done), .rate_err_o(err),
    .blk_cnt_o(cnt));

  aes_prng_reseed_sched #(.SecMasking(1'b0), .CntWidth(14)) u_nm (
    .clk_i(clk), .rst_i(rst), .prng_reseed_rate_i(rate), .key_touch_forces_reseed_i(force_key),
    .block_done_i(blk), .key_touch_i(key), .sw_reseed_i(sw), .reseed_req_o(nm_req),
    .reseed_ack_i(ack), .block_stall_o(nm_stall), .reseed_done_o(nm_done), .rate_err_o(nm_err),
    .blk_cnt_o(nm_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {blk, key, sw, ack} = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);

    // 64 blocks at rate 010
    d0 = n_done;
    blk = 1;
    for (int i = 0; i < 63; i++) tick();
    chk("r64_cnt63", cnt, 63);
    chk("r64_noreq", req, 0);
    tick();
    blk = 0;
    chk("r64_req", req, 1);
    chk("r64_stall", stall, 1);
    tick();
    tick();
    chk("r64_hold", req, 1);
    ack = 1;
    tick();
    ack = 0;
    chk("r64_done", done, 1);
    chk("r64_reqlo", req, 0);
    chk("r64_cnt0", cnt, 0);
    tick();
    chk("r64_done_once", n_done - d0, 1);

    // rate 100, then rate drop triggers immediately; saturation at 8192
    rate = 3'b100;
    blk = 1;
    for (int i = 0; i < 8191; i++) tick();
    blk = 0;
    chk("r8k_cnt", cnt, 8191);
    chk("r8k_noreq", req, 0);
    rate = 3'b010;
    tick();
    chk("rchg_req", req, 1);
    rate = 3'b100;
    blk = 1;
    for (int i = 0; i < 3; i++) tick();
    blk = 0;
    chk("r8k_sat", cnt, 8192);
    ack = 1;
    tick();
    ack = 0;
    chk("r8k_done", done, 1);
    chk("r8k_cnt0", cnt, 0);
    tick();
    chk("r8k_idle_stall", stall, 0);

    // software reseed, second trigger in the ack cycle
    d0 = n_done;
    sw = 1;
    tick();
    sw = 0;
    chk("sw_req", req, 1);
    tick();
    ack = 1;
    sw = 1;
    tick();
    ack = 0;
    sw = 0;
    chk("sw_gap_req", req, 0);
    chk("sw_gap_stall", stall, 1);
    chk("sw_gap_done", done, 1);
    tick();
    chk("sw_req2", req, 1);
    ack = 1;
    tick();
    ack = 0;
    chk("sw_done2", done, 1);
    tick();
    chk("sw_done_total", n_done - d0, 2);
    chk("sw_idle", req, 0);

    // key touch
    key = 1;
    tick();
    key = 0;
    tick();
    chk("key_off_req", req, 0);
    chk("key_off_stall", stall, 0);
    force_key = 1;
    key = 1;
    tick();
    key = 0;
    chk("key_on_req", req, 1);
    ack = 1;
    tick();
    ack = 0;
    force_key = 0;
    chk("key_done", done, 1);
    tick();

    // unmasked build never auto-reseeds
    do_reset();
    rate = 3'b010;
    seen = 0;
    blk = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen |= nm_req;
    end
    blk = 0;
    chk("nm_noreq", seen, 0);
    chk("nm_cnt_sat", nm_cnt, 64);
    chk("m_req", req, 1);

    // invalid rate encoding
    do_reset();
    rate = 3'b011;
    tick();
    chk("err_set", err, 1);
    chk("err_noreq", req, 0);
    blk = 1;
    tick();
    blk = 0;
    chk("err_t1_req", req, 1);
    ack = 1;
    tick();
    ack = 0;
    chk("err_t1_done", done, 1);
    blk = 1;
    tick();
    blk = 0;
    chk("err_t1_req2", req, 1);
    ack = 1;
    rate = 3'b010;
    tick();
    ack = 0;
    tick();
    chk("err_sticky", err, 1);
    chk("err_idle", req, 0);
    do_reset();
    chk("err_clr", err, 0);

    // reset mid-handshake
    sw = 1;
    blk = 1;
    tick();
    sw = 0;
    blk = 0;
    chk("mid_req", req, 1);
    chk("mid_cnt", cnt, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_cnt", cnt, 0);
    ack = 1;
    tick();
    ack = 0;
    chk("late_ack_done", done, 0);
    tick();
    chk("late_ack_done2", done, 0);
    chk("late_ack_req", req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
